// File: rtl/rtc_alarm_pkg.sv
// rtl/rtc_alarm_pkg.sv - shared types and constants for the RTC alarm bank
// The SNOOZE state exists only when RTC_ALARM_SNOOZE_EN is defined.
package rtc_alarm_pkg;

   typedef struct packed {
      logic [5:0] sec;
      logic [5:0] min;
      logic [4:0] hour;
      logic [2:0] dow;
      logic [4:0] dom;
      logic [3:0] month;
   } rtc_time_t;

   // The time field cannot be called "time" because that is a keyword.
   typedef struct packed {
      rtc_time_t  alarm_time;
      logic [5:0] mask;
      logic       periodic;
   } alarm_cfg_t;

   localparam int MSK_SEC   = 0;
   localparam int MSK_MIN   = 1;
   localparam int MSK_HOUR  = 2;
   localparam int MSK_DOW   = 3;
   localparam int MSK_DOM   = 4;
   localparam int MSK_MONTH = 5;

`ifdef RTC_ALARM_SNOOZE_EN
   typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_FIRED, ST_SNOOZE} alarm_state_e;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_FIRED} alarm_state_e;
`endif

endpackage

// File: rtl/rtc_alarm_chan.sv
// rtl/rtc_alarm_chan.sv - one alarm channel: config register, compare, FSM, snooze counter
// The snooze port and its counter are built only with RTC_ALARM_SNOOZE_EN.
module rtc_alarm_chan
   import rtc_alarm_pkg::*;
#(
   parameter int SNOOZE_SEC = 300
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       tick_i,
   input  rtc_time_t  cur_time_i,
   input  logic       cfg_we_i,
   input  alarm_cfg_t cfg_wdata_i,
   input  logic       arm_i,
   input  logic       disarm_i,
   input  logic       ack_i,
`ifdef RTC_ALARM_SNOOZE_EN
   input  logic       snooze_i,
`endif
   output logic       armed_o,
   output logic       irq_o,
   output logic       fire_pulse_o,
   output logic       overrun_o
);

   alarm_cfg_t   cfg;
   alarm_state_e state, state_nxt;
   logic         ovr_nxt, fire_nxt;
   logic [5:0]   eq;
   logic         match;

`ifdef RTC_ALARM_SNOOZE_EN
   localparam int CNT_W = (SNOOZE_SEC > 0) ? $clog2(SNOOZE_SEC + 1) : 1;
   logic [CNT_W-1:0] cnt, cnt_nxt;
`endif

   // Compare uses the registered config, so a same-cycle write sees the old pattern.
   always_comb begin
      eq            = '0;
      eq[MSK_SEC]   = (cfg.alarm_time.sec   == cur_time_i.sec);
      eq[MSK_MIN]   = (cfg.alarm_time.min   == cur_time_i.min);
      eq[MSK_HOUR]  = (cfg.alarm_time.hour  == cur_time_i.hour);
      eq[MSK_DOW]   = (cfg.alarm_time.dow   == cur_time_i.dow);
      eq[MSK_DOM]   = (cfg.alarm_time.dom   == cur_time_i.dom);
      eq[MSK_MONTH] = (cfg.alarm_time.month == cur_time_i.month);
      match         = tick_i && (&(eq | cfg.mask));
   end

   always_comb begin
      state_nxt = state;
      ovr_nxt   = overrun_o;
      fire_nxt  = 1'b0;
`ifdef RTC_ALARM_SNOOZE_EN
      cnt_nxt   = cnt;
`endif
      if (disarm_i) begin
         state_nxt = ST_IDLE;
         ovr_nxt   = 1'b0;
      end else begin
         case (state)
            ST_IDLE:  if (arm_i) state_nxt = ST_ARMED;
            ST_ARMED: if (match) begin
               state_nxt = ST_FIRED;
               fire_nxt  = 1'b1;
            end
            ST_FIRED: if (ack_i) begin
               ovr_nxt = 1'b0;
               if (cfg.periodic) begin
                  if (match) fire_nxt = 1'b1;
                  else       state_nxt = ST_ARMED;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
`ifdef RTC_ALARM_SNOOZE_EN
            else if (snooze_i) begin
               state_nxt = ST_SNOOZE;
               cnt_nxt   = CNT_W'(SNOOZE_SEC);
            end
`endif
            else if (match) begin
               fire_nxt = 1'b1;
               ovr_nxt  = 1'b1;
            end
`ifdef RTC_ALARM_SNOOZE_EN
            ST_SNOOZE: if (ack_i) begin
               ovr_nxt   = 1'b0;
               state_nxt = cfg.periodic ? ST_ARMED : ST_IDLE;
            end else if (tick_i) begin
               if (cnt <= CNT_W'(1)) begin
                  state_nxt = ST_FIRED;
                  fire_nxt  = 1'b1;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt - CNT_W'(1);
               end
            end
`endif
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= ST_IDLE;
         cfg          <= '0;
         overrun_o    <= 1'b0;
         fire_pulse_o <= 1'b0;
`ifdef RTC_ALARM_SNOOZE_EN
         cnt          <= '0;
`endif
      end else begin
         state        <= state_nxt;
         overrun_o    <= ovr_nxt;
         fire_pulse_o <= fire_nxt;
         if (cfg_we_i) cfg <= cfg_wdata_i;
`ifdef RTC_ALARM_SNOOZE_EN
         cnt          <= cnt_nxt;
`endif
      end
   end

   assign armed_o = (state != ST_IDLE);
   assign irq_o   = (state == ST_FIRED);

endmodule

// File: rtl/rtc_alarm_bank.sv
// rtl/rtc_alarm_bank.sv - NUM_ALARMS-channel RTC alarm engine with latched interrupts
// Defining RTC_ALARM_SNOOZE_EN adds the snooze_i port and per-channel snooze.
module rtc_alarm_bank
   import rtc_alarm_pkg::*;
#(
   parameter  int NUM_ALARMS = 4,
   parameter  int SNOOZE_SEC = 300,
   localparam int IDX_W      = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  tick_i,
   input  rtc_time_t             cur_time_i,
   input  logic                  cfg_we_i,
   input  logic [IDX_W-1:0]      cfg_idx_i,
   input  alarm_cfg_t            cfg_wdata_i,
   input  logic [NUM_ALARMS-1:0] arm_i,
   input  logic [NUM_ALARMS-1:0] disarm_i,
   input  logic [NUM_ALARMS-1:0] ack_i,
`ifdef RTC_ALARM_SNOOZE_EN
   input  logic [NUM_ALARMS-1:0] snooze_i,
`endif
   output logic [NUM_ALARMS-1:0] armed_o,
   output logic [NUM_ALARMS-1:0] irq_o,
   output logic                  irq_any_o,
   output logic [NUM_ALARMS-1:0] fire_pulse_o,
   output logic [NUM_ALARMS-1:0] overrun_o
);

   logic [NUM_ALARMS-1:0] cfg_we;

   // Out-of-range indices decode to no channel.
   always_comb begin
      cfg_we = '0;
      for (int i = 0; i < NUM_ALARMS; i++)
         cfg_we[i] = cfg_we_i && (cfg_idx_i == IDX_W'(i));
   end

   for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_chan
      rtc_alarm_chan #(.SNOOZE_SEC(SNOOZE_SEC)) u_chan (
         .clk_i        (clk_i),
         .rst_i        (rst_i),
         .tick_i       (tick_i),
         .cur_time_i   (cur_time_i),
         .cfg_we_i     (cfg_we[g]),
         .cfg_wdata_i  (cfg_wdata_i),
         .arm_i        (arm_i[g]),
         .disarm_i     (disarm_i[g]),
         .ack_i        (ack_i[g]),
`ifdef RTC_ALARM_SNOOZE_EN
         .snooze_i     (snooze_i[g]),
`endif
         .armed_o      (armed_o[g]),
         .irq_o        (irq_o[g]),
         .fire_pulse_o (fire_pulse_o[g]),
         .overrun_o    (overrun_o[g])
      );
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) irq_any_o <= 1'b0;
      else       irq_any_o <= |irq_o;
   end

endmodule

// File: tb/tb_rtc_alarm_bank.sv
// tb/tb_rtc_alarm_bank.sv - self-checking bench for rtc_alarm_bank (snooze checks with RTC_ALARM_SNOOZE_EN)
module tb_rtc_alarm_bank;
   import rtc_alarm_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, tick, we, we1, idx1, arm1, ack1;
   rtc_time_t  cur;
   logic [1:0] idx;
   alarm_cfg_t wd, wd1;
   logic [3:0] arm, dis, ack;
   logic [3:0] armed, irq, fire, ovr;
   logic       irq_any, armed1, irq1, fire1, ovr1, irq_any1;
`ifdef RTC_ALARM_SNOOZE_EN
   logic [3:0] snz;
   logic       snz1;
`endif

   rtc_alarm_bank #(.NUM_ALARMS(4), .SNOOZE_SEC(3)) dut (
      .clk_i(clk), .rst_i(rst), .tick_i(tick), .cur_time_i(cur),
      .cfg_we_i(we), .cfg_idx_i(idx), .cfg_wdata_i(wd),
      .arm_i(arm), .disarm_i(dis), .ack_i(ack),
`ifdef RTC_ALARM_SNOOZE_EN
      .snooze_i(snz),
`endif
      .armed_o(armed), .irq_o(irq), .irq_any_o(irq_any),
      .fire_pulse_o(fire), .overrun_o(ovr)
   );

   rtc_alarm_bank #(.NUM_ALARMS(1), .SNOOZE_SEC(3)) dut1 (
      .clk_i(clk), .rst_i(rst), .tick_i(tick), .cur_time_i(cur),
      .cfg_we_i(we1), .cfg_idx_i(idx1), .cfg_wdata_i(wd1),
      .arm_i(arm1), .disarm_i(1'b0), .ack_i(ack1),
`ifdef RTC_ALARM_SNOOZE_EN
      .snooze_i(snz1),
`endif
      .armed_o(armed1), .irq_o(irq1), .irq_any_o(irq_any1),
      .fire_pulse_o(fire1), .overrun_o(ovr1)
   );

   typedef struct {
      logic       tk;
      rtc_time_t  t;
      logic       w;
      logic [1:0] ix;
      alarm_cfg_t c;
      logic [3:0] a, d, k;
      logic [3:0] e_armed, e_irq, e_fire, e_ovr;
   } vec_t;

   typedef struct {
      logic [3:0] armed, irq, fire, ovr;
      logic       any;
   } exp_t;

   exp_t sbq[$];
   vec_t tv[21];
   int   checks   = 0;
   int   failures = 0;

   function automatic rtc_time_t tm(int h, int m, int s);
      rtc_time_t r;
      r.sec = 6'(s); r.min = 6'(m); r.hour = 5'(h);
      r.dow = 3'd3;  r.dom = 5'd15; r.month = 4'd6;
      return r;
   endfunction

   function automatic alarm_cfg_t mkcfg(int h, int m, int s, logic [5:0] mask, logic per);
      alarm_cfg_t c;
      c.alarm_time = tm(h, m, s);
      c.mask       = mask;
      c.periodic   = per;
      return c;
   endfunction

   function automatic vec_t mkv(logic tk, rtc_time_t t, logic w, logic [1:0] ix, alarm_cfg_t c,
                                logic [3:0] a, logic [3:0] d, logic [3:0] k,
                                logic [3:0] ea, logic [3:0] ei, logic [3:0] ef, logic [3:0] eo);
      vec_t v;
      v.tk = tk; v.t = t; v.w = w; v.ix = ix; v.c = c; v.a = a; v.d = d; v.k = k;
      v.e_armed = ea; v.e_irq = ei; v.e_fire = ef; v.e_ovr = eo;
      return v;
   endfunction

   task automatic chk(string name, logic [3:0] act, logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      tick = 1'b0; we = 1'b0; idx = '0; wd = '0; arm = '0; dis = '0; ack = '0;
      we1 = 1'b0; idx1 = 1'b0; wd1 = '0; arm1 = 1'b0; ack1 = 1'b0;
      cur = tm(0, 0, 0);
`ifdef RTC_ALARM_SNOOZE_EN
      snz = '0; snz1 = 1'b0;
`endif
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(string name, logic [3:0] ea, logic [3:0] ei, logic [3:0] ef, logic [3:0] eo);
      chk({name, " armed"}, armed, ea);
      chk({name, " irq"},   irq,   ei);
      chk({name, " fire"},  fire,  ef);
      chk({name, " ovr"},   ovr,   eo);
   endtask

   alarm_cfg_t cA, cB, cC, cD;
   logic [3:0] prev_irq;
   exp_t       e;

   initial begin
      cA = mkcfg(7, 30, 45, 6'b111001, 1'b0);
      cB = mkcfg(0, 0, 0, 6'h3F, 1'b1);
      cC = mkcfg(0, 0, 5, 6'b111110, 1'b0);
      cD = mkcfg(0, 0, 10, 6'b111110, 1'b0);

      tv[0]  = mkv(0, tm(0,0,0),   1, 2'd0, cA, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      tv[1]  = mkv(0, tm(0,0,0),   1, 2'd1, cB, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      tv[2]  = mkv(0, tm(0,0,0),   1, 2'd2, cC, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      tv[3]  = mkv(0, tm(0,0,0),   0, 2'd0, cA, 4'b0111, 4'b0000, 4'b0000, 4'b0111, 4'b0000, 4'b0000, 4'b0000);
      tv[4]  = mkv(1, tm(7,30,0),  0, 2'd0, cA, 4'b0000, 4'b0000, 4'b0000, 4'b0111, 4'b0011, 4'b0011, 4'b0000);
      tv[5]  = mkv(0, tm(7,30,0),  0, 2'd0, cA, 4'b0000, 4'b0000, 4'b0000, 4'b0111, 4'b0011, 4'b0000, 4'b0000);
      tv[6]  = mkv(0, tm(7,30,0),  0, 2'd0, cA, 4'b0000, 4'b0000, 4'b0001, 4'b0110, 4'b0010, 4'b0000, 4'b0000);
      tv[7]  = mkv(1, tm(7,30,1),  0, 2'd0, cA, 4'b0000, 4'b0000, 4'b0000, 4'b0110, 4'b0010, 4'b0010, 4'b0010);
      tv[8]  = mkv(1, tm(7,30,2),  0, 2'd0, cA, 4'b0000, 4'b0000, 4'b0010, 4'b0110, 4'b0010, 4'b0010, 4'b0000);
      tv[9]  = mkv(1, tm(7,30,10), 1, 2'd2, cD, 4'b0000, 4'b0000, 4'b0000, 4'b0110, 4'b0010, 4'b0010, 4'b0010);
      tv[10] = mkv(1, tm(7,30,10), 0, 2'd0, cA, 4'b0000, 4'b0000, 4'b0000, 4'b0110, 4'b0110, 4'b0110, 4'b0010);
      tv[11] = mkv(0, tm(7,30,10), 0, 2'd0, cA, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
      tv[12] = mkv(1, tm(7,30,10), 0, 2'd0, cA, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100);
      tv[13] = mkv(0, tm(7,30,10), 0, 2'd0, cA, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      tv[14] = mkv(0, tm(7,30,10), 0, 2'd0, cA, 4'b0001, 4'b0000, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      tv[15] = mkv(1, tm(8,30,0),  0, 2'd0, cA, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      tv[16] = mkv(1, tm(7,30,59), 0, 2'd0, cA, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
      tv[17] = mkv(1, tm(7,30,0),  0, 2'd0, cA, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      tv[18] = mkv(0, tm(0,0,0),   1, 2'd3, cB, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
      tv[19] = mkv(1, tm(1,2,3),   0, 2'd0, cA, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000);
      tv[20] = mkv(0, tm(1,2,3),   0, 2'd0, cA, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

      idle_inputs();
      rst = 1'b1;
      step();
      step();
      chk_all("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      chk("reset irq_any", {3'b0, irq_any}, 4'b0000);
      rst = 1'b0;

      prev_irq = 4'b0000;
      for (int i = 0; i < 21; i++) begin
         tick = tv[i].tk; cur = tv[i].t; we = tv[i].w; idx = tv[i].ix; wd = tv[i].c;
         arm = tv[i].a; dis = tv[i].d; ack = tv[i].k;
         sbq.push_back('{armed: tv[i].e_armed, irq: tv[i].e_irq, fire: tv[i].e_fire,
                         ovr: tv[i].e_ovr, any: |prev_irq});
         prev_irq = tv[i].e_irq;
         step();
         e = sbq.pop_front();
         chk_all($sformatf("v%0d", i), e.armed, e.irq, e.fire, e.ovr);
         chk($sformatf("v%0d irq_any", i), {3'b0, irq_any}, {3'b0, e.any});
      end
      idle_inputs();
      step();

      // Reset while a channel is FIRED clears everything on the same edge.
      arm = 4'b0010; step(); idle_inputs();
      tick = 1'b1; step(); idle_inputs();
      chk("pre-rst irq", irq, 4'b0010);
      rst = 1'b1; tick = 1'b1; arm = 4'b1111;
      step();
      chk_all("rst fired", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      chk("rst irq_any", {3'b0, irq_any}, 4'b0000);
      rst = 1'b0; idle_inputs(); step();

      // Single-channel bank: an index of 1 must not reach channel 0.
      we1 = 1'b1; idx1 = 1'b0; wd1 = mkcfg(0, 0, 5, 6'b111110, 1'b0); step();
      we1 = 1'b1; idx1 = 1'b1; wd1 = mkcfg(0, 0, 20, 6'h3F, 1'b1); step();
      idle_inputs(); arm1 = 1'b1; step();
      chk("n1 armed", {3'b0, armed1}, 4'b0001);
      idle_inputs(); tick = 1'b1; cur = tm(0, 0, 20); step();
      chk("n1 no fire", {2'b0, fire1, irq1}, 4'b0000);
      idle_inputs(); tick = 1'b1; cur = tm(0, 0, 5); step();
      chk("n1 fire", {2'b0, fire1, irq1}, 4'b0011);
      idle_inputs(); step();

`ifdef RTC_ALARM_SNOOZE_EN
      we = 1'b1; idx = 2'd1; wd = cB; arm = 4'b0010; step(); idle_inputs();
      tick = 1'b1; step(); idle_inputs();
      chk("sz fired", irq, 4'b0010);
      snz = 4'b0010; step(); idle_inputs();
      chk_all("sz enter", 4'b0010, 4'b0000, 4'b0000, 4'b0000);
      for (int t = 1; t <= 3; t++) begin
         tick = 1'b1; step(); idle_inputs();
         chk($sformatf("sz tick%0d irq", t), irq, (t == 3) ? 4'b0010 : 4'b0000);
         chk($sformatf("sz tick%0d fire", t), fire, (t == 3) ? 4'b0010 : 4'b0000);
      end
      snz = 4'b0010; step(); idle_inputs();
      tick = 1'b1; step(); idle_inputs();
      chk("sz mid irq", irq, 4'b0000);
      rst = 1'b1; step();
      chk_all("sz rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      rst = 1'b0; step();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rtc_alarm_bank.md
# rtc_alarm_bank

Parametrised multi-channel alarm engine for the RTC. It compares the current calendar time from the time counter against NUM_ALARMS independently configured alarm patterns on every 1 Hz tick. It raises latched per-channel interrupts with one-shot or periodic re-arm and overrun detection. It sits between the time counter outputs and the APB register file, which supplies configuration and consumes interrupts and status.

## Interface
- NUM_ALARMS, 4: number of alarm channels, 1..16
- SNOOZE_SEC, 300: snooze length in ticks; used only with RTC_ALARM_SNOOZE_EN
- IDX_W, derived: max(1, $clog2(NUM_ALARMS)); not user-set

- clk_i  in  1  system clock; single clock domain
- rst_i  in  1  synchronous reset, active-high
- tick_i  in  1  1 Hz strobe, one clk_i cycle wide; time inputs are stable during it
- cur_time_i  in  29  rtc_time_t {sec[5:0], min[5:0], hour[4:0], dow[2:0], dom[4:0], month[3:0]}, binary
- cfg_we_i  in  1  write the alarm configuration selected by cfg_idx_i
- cfg_idx_i  in  IDX_W  channel index; writes with index ≥ NUM_ALARMS are ignored
- cfg_wdata_i  in  36  alarm_cfg_t {time rtc_time_t, mask[5:0], periodic}; mask bit set = field is don't-care
- arm_i  in  NUM_ALARMS  per-channel arm pulse
- disarm_i  in  NUM_ALARMS  per-channel disarm pulse
- ack_i  in  NUM_ALARMS  per-channel interrupt acknowledge pulse
- snooze_i  in  NUM_ALARMS  per-channel snooze pulse; present only with RTC_ALARM_SNOOZE_EN
- armed_o  out  NUM_ALARMS  channel is in ARMED, FIRED or SNOOZE
- irq_o  out  NUM_ALARMS  level interrupt, high in FIRED
- irq_any_o  out  1  registered OR of irq_o
- fire_pulse_o  out  NUM_ALARMS  one-cycle pulse on each match event
- overrun_o  out  NUM_ALARMS  sticky: a match occurred while already FIRED

## Operation
- Per-channel FSM with states IDLE, ARMED, FIRED and SNOOZE (SNOOZE only with the macro).
- Match condition: tick_i is high and every unmasked field of cfg equals cur_time_i. With mask = 6'h3F the channel matches on every tick.
- State transitions:
  - IDLE → ARMED on arm_i.
  - ARMED → FIRED on match; fire_pulse_o pulses.
  - FIRED + ack_i → ARMED if periodic=1, otherwise IDLE. overrun_o clears on ack.
  - FIRED + match with no ack → stays FIRED; fire_pulse_o pulses; overrun_o sets.
  - FIRED + ack_i + match in the same cycle: periodic=1 stays FIRED, overrun cleared, fire pulse issued. periodic=0 goes to IDLE; the match is dropped.
  - disarm_i from any state → IDLE; overrun cleared.
- Priority: disarm_i > ack_i > arm_i.
  - arm_i in a non-IDLE state is ignored.
  - ack_i outside FIRED/SNOOZE is ignored.
- Config write: cfg_we_i loads the register on the next clock edge. A tick in the same cycle as a write compares against the old config. Writes are allowed in any state and do not change state.
- Reset: all channels IDLE, cfg registers all zero (mask=0, periodic=0), and all outputs 0.

## Timing
- Match detection is registered. irq_o, fire_pulse_o and overrun_o update on the edge that samples tick_i, so they are visible one cycle after tick_i.
- irq_any_o lags irq_o by one cycle.
- arm/disarm/ack take effect on the next edge. armed_o reflects the new state one cycle after the pulse.
- rst_i has priority over every input. Asserting it mid-snooze or while FIRED clears all state in the same edge.
- Inputs must be synchronous to clk_i. No CDC inside the block.

## Configuration
- RTC_ALARM_SNOOZE_EN defined:
  - snooze_i is present and SNOOZE is a live state.
  - FIRED + snooze_i → SNOOZE; irq_o drops and a counter loads SNOOZE_SEC.
  - The counter decrements on each tick_i. When it reaches 0 on a tick, the channel returns to FIRED, irq_o rises again and fire_pulse_o pulses.
  - Matches are ignored during SNOOZE.
  - ack_i in SNOOZE behaves as in FIRED.
  - Counter width is $clog2(SNOOZE_SEC+1).
- RTC_ALARM_SNOOZE_EN undefined: no snooze_i port, no SNOOZE state and no counter logic.

## Structure
- Package rtc_alarm_pkg holds:
  - rtc_time_t and alarm_cfg_t packed structs
  - mask bit position constants (MSK_SEC=0 … MSK_MONTH=5)
  - the alarm_state_e enum
- Sub-module rtc_alarm_chan contains one channel (cfg register, FSM, snooze counter, compare) and is instantiated NUM_ALARMS times in a generate loop.
- The top level contains the config write decode, the irq_any_o OR, and the output vector packing.

## Test plan
- Channel 0: cfg hour=7, min=30, mask=6'b111001 (sec/dow/dom/month don't-care), arm, drive 07:30:00 with tick → irq_o[0]=1 and one fire_pulse_o[0] one cycle after tick; ack → IDLE, armed_o[0]=0.
- Periodic channel with mask=6'h3F: two ticks without ack → overrun_o set after the second tick; ack with a tick in the same cycle → still FIRED, overrun_o=0.
- disarm_i, arm_i and ack_i in the same cycle on a FIRED channel → IDLE; all outputs for that channel 0.
- cfg write carrying new sec=10 in the same cycle as a tick at sec=10, with old sec=5 → no fire; the next matching tick at sec=10 fires.
- With the macro and SNOOZE_SEC=3: FIRED → snooze → irq low for 3 ticks, then re-fires on the 3rd tick; assert rst_i mid-snooze → all outputs 0 on the next edge.
- With NUM_ALARMS=1: cfg_idx_i=1 write is ignored; channel 0 config is unchanged.
